// File: rtl/bus_stall_bridge.sv
// bus_stall_bridge
//   Maps an address window of the rv32 CPU bus onto a slow peripheral that
//   signals completion with a busy handshake. A window hit halts the CPU and
//   sends a one-cycle request to the peripheral. The bridge then waits for
//   module_busy_i to drop, returns the captured read data, and releases the
//   halt.
//
//   Optional feature macro: BUS_STALL_TIMEOUT_EN
//     defined   -> a watchdog aborts a WAIT after TIMEOUT_CYCLES busy-high
//                  cycles. On abort it returns TIMEOUT_DATA and sets the
//                  sticky timeout_o.
//     undefined -> WAIT exits only when busy is low, timeout_o is tied 0 and
//                  timeout_clr_i is ignored.
//
// Ports
//   clk_i          in   sole clock, rising edge
//   reset_i        in   asynchronous active-low reset
//   address_i      in   CPU address
//   data_i         in   CPU write data
//   we_i           in   CPU write enable (qualified by req_i)
//   req_i          in   one-cycle CPU access strobe
//   cpu_halt_o     out  stall to CPU
//   rdata_o        out  completed read data, held until next completion
//   rdata_valid_o  out  one-cycle completion pulse
//   mod_address_o  out  latched window offset (address_i - BASE_ADDR)
//   mod_data_o     out  latched write data
//   mod_we_o       out  latched write flag, valid with mod_req_o
//   mod_req_o      out  one-cycle request to peripheral
//   mod_data_i     in   peripheral read data
//   module_busy_i  in   peripheral busy
//   timeout_o      out  sticky abort flag
//   timeout_clr_i  in   clears timeout_o
//
// States
//   IDLE  | no access in flight
//   ISSUE | mod_req_o pulsed, watchdog cleared
//   WAIT  | waiting for module_busy_i low (or watchdog expiry)
//   DONE  | rdata_valid_o pulse; a new hit may be accepted here

module bus_stall_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_9000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0000_0100,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we_i,
    input  logic                  req_i,
    output logic                  cpu_halt_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic [ADDR_WIDTH-1:0] mod_address_o,
    output logic [DATA_WIDTH-1:0] mod_data_o,
    output logic                  mod_we_o,
    output logic                  mod_req_o,
    input  logic [DATA_WIDTH-1:0] mod_data_i,
    input  logic                  module_busy_i,
    output logic                  timeout_o,
    input  logic                  timeout_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic complete;
    logic abort;
    logic timeout_hit;
    logic hit;

    // Window compare is done one bit wider so BASE_ADDR+ADDR_SPAN cannot wrap.
    logic [ADDR_WIDTH:0] addr_ext;
    logic [ADDR_WIDTH:0] win_lo;
    logic [ADDR_WIDTH:0] win_hi;

    assign addr_ext = {1'b0, address_i};
    assign win_lo   = {1'b0, BASE_ADDR};
    assign win_hi   = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};
    assign hit      = (addr_ext >= win_lo) && (addr_ext < win_hi);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (req_i && hit) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!module_busy_i) begin
                    complete   = 1'b1;
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The accept term stalls the CPU in the request cycle itself, and keeps
    // halt high through DONE when a back-to-back hit arrives there.
    assign cpu_halt_o    = (state == S_ISSUE) || (state == S_WAIT) || accept;
    assign mod_req_o     = (state == S_ISSUE);
    assign rdata_valid_o = (state == S_DONE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mod_address_o <= '0;
            mod_data_o    <= '0;
            mod_we_o      <= 1'b0;
            rdata_o       <= '0;
        end else begin
            if (accept) begin
                mod_address_o <= address_i - BASE_ADDR;
                mod_data_o    <= data_i;
                mod_we_o      <= we_i;
            end
            if (complete) begin
                rdata_o <= mod_data_i;
            end else if (abort) begin
                rdata_o <= TIMEOUT_DATA;
            end
        end
    end

`ifdef BUS_STALL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // wd_cnt holds the number of earlier busy-high WAIT cycles, so the
    // TIMEOUT_CYCLES-th busy cycle is the one that sees TIMEOUT_CYCLES-1.
    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if ((state == S_WAIT) && module_busy_i && !timeout_hit) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // A fresh abort wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            timeout_o <= 1'b0;
        end else if (abort) begin
            timeout_o <= 1'b1;
        end else if (timeout_clr_i) begin
            timeout_o <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = timeout_clr_i ^ (TIMEOUT_CYCLES < 2);
`endif

endmodule

// File: tb/tb_bus_stall_bridge.sv
`timescale 1ns/1ps

module tb_bus_stall_bridge;

    localparam logic [31:0] BASE = 32'h0000_9000;
    localparam logic [31:0] SPAN = 32'h0000_0100;
    localparam int          TMO  = 16;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] address_i = '0;
    logic [31:0] data_i = '0;
    logic        we_i = 1'b0;
    logic        req_i = 1'b0;
    logic        cpu_halt_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic [31:0] mod_address_o;
    logic [31:0] mod_data_o;
    logic        mod_we_o;
    logic        mod_req_o;
    logic [31:0] mod_data_i = '0;
    logic        module_busy_i = 1'b0;
    logic        timeout_o;
    logic        timeout_clr_i = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        int          done_cyc;
        int          halt_cnt;
        int          req_cyc;
        logic [31:0] off;
        logic        we;
        logic [31:0] wdata;
        logic        tmo;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    bus_stall_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (BASE),
        .ADDR_SPAN     (SPAN),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .address_i    (address_i),
        .data_i       (data_i),
        .we_i         (we_i),
        .req_i        (req_i),
        .cpu_halt_o   (cpu_halt_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .mod_address_o(mod_address_o),
        .mod_data_o   (mod_data_o),
        .mod_we_o     (mod_we_o),
        .mod_req_o    (mod_req_o),
        .mod_data_i   (mod_data_i),
        .module_busy_i(module_busy_i),
        .timeout_o    (timeout_o),
        .timeout_clr_i(timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Drives one access (request in cycle 0) and plays a peripheral that is
    // busy for busy_n cycles starting the cycle after mod_req_o. Only
    // observes; all checking is done by the calling test.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                              input logic we, input int busy_n, output rec_t got);
        int rem;
        bit req_seen;
        rem          = 0;
        got.rdata    = 'x;
        got.done_cyc = -1;
        got.halt_cnt = 0;
        got.req_cyc  = -1;
        got.off      = 'x;
        got.we       = 1'bx;
        got.wdata    = 'x;
        got.tmo      = 1'bx;
        @(posedge clk_i); #1;
        address_i = addr;
        data_i    = wd;
        we_i      = we;
        req_i     = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_i);
            req_seen = mod_req_o;
            if (cpu_halt_o) got.halt_cnt++;
            if (mod_req_o && got.req_cyc < 0) begin
                got.req_cyc = c;
                got.off     = mod_address_o;
                got.we      = mod_we_o;
                got.wdata   = mod_data_o;
            end
            if (rdata_valid_o) begin
                got.done_cyc = c;
                got.rdata    = rdata_o;
                got.tmo      = timeout_o;
                break;
            end
            @(posedge clk_i); #1;
            req_i = 1'b0;
            if (req_seen && busy_n > 0) begin
                module_busy_i = 1'b1;
                rem = busy_n;
            end else if (module_busy_i) begin
                rem--;
                if (rem == 0) module_busy_i = 1'b0;
            end
        end
        req_i = 1'b0;
        module_busy_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_cmp++;
        if ({cpu_halt_o, rdata_valid_o, mod_req_o, mod_we_o, timeout_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {cpu_halt_o, rdata_valid_o, mod_req_o, mod_we_o, timeout_o});
        end
        n_cmp++;
        if ({rdata_o, mod_address_o, mod_data_o} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h expected zeros", rdata_o, mod_address_o, mod_data_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (cpu_halt_o !== 1'b0 || mod_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: halt=%b req=%b expected 0 0", cpu_halt_o, mod_req_o);
        end
    endtask

    task automatic test_read();
        rec_t got, e;
        mod_data_i = 32'h1234_5678;
        sb.push_back('{rdata:32'h1234_5678, done_cyc:3, halt_cnt:3, req_cyc:1,
                       off:32'd4, we:1'b0, wdata:32'h0, tmo:1'b0});
        run_access(BASE + 32'd4, 32'h0, 1'b0, 0, got);
        e = sb.pop_front();
        n_cmp++;
        if (got.req_cyc !== e.req_cyc || got.off !== e.off || got.we !== e.we) begin
            n_fail++;
            $display("FAIL read_req: got cyc=%0d off=%h we=%b expected cyc=%0d off=%h we=%b",
                     got.req_cyc, got.off, got.we, e.req_cyc, e.off, e.we);
        end
        n_cmp++;
        if (got.done_cyc !== e.done_cyc || got.rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL read_done: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                     got.done_cyc, got.rdata, e.done_cyc, e.rdata);
        end
        n_cmp++;
        if (got.halt_cnt !== e.halt_cnt) begin
            n_fail++;
            $display("FAIL read_halt: got %0d expected %0d", got.halt_cnt, e.halt_cnt);
        end
    endtask

    task automatic test_write();
        rec_t got, e;
        mod_data_i = 32'h0BAD_0BAD;
        sb.push_back('{rdata:32'h0, done_cyc:8, halt_cnt:8, req_cyc:1,
                       off:32'd8, we:1'b1, wdata:32'hA5A5_0001, tmo:1'b0});
        run_access(BASE + 32'd8, 32'hA5A5_0001, 1'b1, 5, got);
        e = sb.pop_front();
        n_cmp++;
        if (got.we !== e.we || got.wdata !== e.wdata || got.off !== e.off) begin
            n_fail++;
            $display("FAIL write_req: got we=%b data=%h off=%h expected we=%b data=%h off=%h",
                     got.we, got.wdata, got.off, e.we, e.wdata, e.off);
        end
        n_cmp++;
        if (got.done_cyc !== e.done_cyc || got.halt_cnt !== e.halt_cnt) begin
            n_fail++;
            $display("FAIL write_timing: got done=%0d halt=%0d expected done=%0d halt=%0d",
                     got.done_cyc, got.halt_cnt, e.done_cyc, e.halt_cnt);
        end
    endtask

    task automatic test_window_edges();
        logic [31:0] miss_addr [2];
        rec_t got, e;
        bit   any_req;
        miss_addr[0] = BASE + SPAN;
        miss_addr[1] = BASE - 32'd4;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            address_i = miss_addr[i];
            we_i = 1'b0;
            req_i = 1'b1;
            @(negedge clk_i);
            n_cmp++;
            if (cpu_halt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_halt[%0d]: got %b expected 0", i, cpu_halt_o);
            end
            @(posedge clk_i); #1;
            req_i = 1'b0;
            any_req = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                if (mod_req_o || cpu_halt_o) any_req = 1'b1;
            end
            n_cmp++;
            if (any_req !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_req[%0d]: got activity=%b expected 0", i, any_req);
            end
        end
        mod_data_i = 32'h0000_00FC;
        sb.push_back('{rdata:32'h0000_00FC, done_cyc:4, halt_cnt:4, req_cyc:1,
                       off:32'hFC, we:1'b0, wdata:32'h0, tmo:1'b0});
        run_access(BASE + SPAN - 32'd4, 32'h0, 1'b0, 1, got);
        e = sb.pop_front();
        n_cmp++;
        if (got.off !== e.off || got.done_cyc !== e.done_cyc || got.rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL last_word: got off=%h done=%0d rdata=%h expected off=%h done=%0d rdata=%h",
                     got.off, got.done_cyc, got.rdata, e.off, e.done_cyc, e.rdata);
        end
    endtask

    task automatic test_timeout();
        rec_t got, e;
        mod_data_i = 32'h5555_AAAA;
`ifdef BUS_STALL_TIMEOUT_EN
        sb.push_back('{rdata:32'hDEAD_BEEF, done_cyc:TMO + 2, halt_cnt:TMO + 2, req_cyc:1,
                       off:32'h10, we:1'b0, wdata:32'h0, tmo:1'b1});
        run_access(BASE + 32'h10, 32'h0, 1'b0, 1000, got);
`else
        sb.push_back('{rdata:32'h5555_AAAA, done_cyc:23, halt_cnt:23, req_cyc:1,
                       off:32'h10, we:1'b0, wdata:32'h0, tmo:1'b0});
        run_access(BASE + 32'h10, 32'h0, 1'b0, 20, got);
`endif
        e = sb.pop_front();
        n_cmp++;
        if (got.done_cyc !== e.done_cyc || got.rdata !== e.rdata || got.tmo !== e.tmo) begin
            n_fail++;
            $display("FAIL timeout_done: got done=%0d rdata=%h tmo=%b expected done=%0d rdata=%h tmo=%b",
                     got.done_cyc, got.rdata, got.tmo, e.done_cyc, e.rdata, e.tmo);
        end
        @(negedge clk_i);
        n_cmp++;
        if (timeout_o !== e.tmo) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected %b", timeout_o, e.tmo);
        end
        @(posedge clk_i); #1;
        timeout_clr_i = 1'b1;
        @(posedge clk_i); #1;
        timeout_clr_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        rec_t got, e;
        @(posedge clk_i); #1;
        address_i = BASE + 32'h30;
        data_i = 32'h7777_0000;
        we_i = 1'b1;
        req_i = 1'b1;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        @(posedge clk_i); #1;
        module_busy_i = 1'b1;
        @(posedge clk_i); #3;
        n_cmp++;
        if (cpu_halt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_wait: halt=%b expected 1", cpu_halt_o);
        end
        reset_i = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_halt_o, rdata_valid_o, mod_req_o, mod_we_o, timeout_o} !== 5'b0 ||
            {rdata_o, mod_address_o, mod_data_o} !== 96'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ctrl=%b rdata=%h addr=%h data=%h expected all 0",
                     {cpu_halt_o, rdata_valid_o, mod_req_o, mod_we_o, timeout_o},
                     rdata_o, mod_address_o, mod_data_o);
        end
        module_busy_i = 1'b0;
        we_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        mod_data_i = 32'hC0DE_0001;
        sb.push_back('{rdata:32'hC0DE_0001, done_cyc:3, halt_cnt:3, req_cyc:1,
                       off:32'h0, we:1'b0, wdata:32'h0, tmo:1'b0});
        run_access(BASE, 32'h0, 1'b0, 0, got);
        e = sb.pop_front();
        n_cmp++;
        if (got.done_cyc !== e.done_cyc || got.rdata !== e.rdata || got.halt_cnt !== e.halt_cnt) begin
            n_fail++;
            $display("FAIL post_reset_read: got done=%0d rdata=%h halt=%0d expected done=%0d rdata=%h halt=%0d",
                     got.done_cyc, got.rdata, got.halt_cnt, e.done_cyc, e.rdata, e.halt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        rec_t e;
        int   halt_cnt;
        int   req_cycles[$];
        int   n_done;
        bit   halt_in_done;
        halt_cnt = 0;
        n_done = 0;
        halt_in_done = 1'b0;
        mod_data_i = 32'h1111_0001;
        sb.push_back('{rdata:32'h1111_0001, done_cyc:3, halt_cnt:0, req_cyc:1,
                       off:32'h20, we:1'b0, wdata:32'h0, tmo:1'b0});
        @(posedge clk_i); #1;
        address_i = BASE + 32'h20;
        we_i = 1'b0;
        req_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (cpu_halt_o) halt_cnt++;
            if (mod_req_o) req_cycles.push_back(c);
            if (rdata_valid_o) begin
                if (c == 3) halt_in_done = cpu_halt_o;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_valid: cycle %0d with empty scoreboard", c);
                end else begin
                    e = sb.pop_front();
                    n_done++;
                    if (c !== e.done_cyc || rdata_o !== e.rdata) begin
                        n_fail++;
                        $display("FAIL b2b_done%0d: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                                 n_done, c, rdata_o, e.done_cyc, e.rdata);
                    end
                end
            end
            @(posedge clk_i); #1;
            req_i = 1'b0;
            if (c + 1 == 3) begin
                mod_data_i = 32'h2222_0002;
                sb.push_back('{rdata:32'h2222_0002, done_cyc:6, halt_cnt:0, req_cyc:4,
                               off:32'h24, we:1'b0, wdata:32'h0, tmo:1'b0});
                address_i = BASE + 32'h24;
                req_i = 1'b1;
            end
        end
        n_cmp++;
        if (n_done !== 2 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d completions, %0d pending expected 2, 0", n_done, sb.size());
        end
        n_cmp++;
        if (req_cycles.size() !== 2 || (req_cycles.size() == 2 && (req_cycles[0] !== 1 || req_cycles[1] !== 4))) begin
            n_fail++;
            $display("FAIL b2b_req_cycles: got %p expected '{1, 4}", req_cycles);
        end
        n_cmp++;
        if (halt_cnt !== 6 || halt_in_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_halt: got cnt=%0d in_done=%b expected cnt=6 in_done=1", halt_cnt, halt_in_done);
        end
        n_cmp++;
        if (mod_address_o !== 32'h24) begin
            n_fail++;
            $display("FAIL b2b_addr: got %h expected 00000024", mod_address_o);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_read();
        test_write();
        test_window_edges();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
